fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction fetch unit for the MIPS core, sitting between the execute-stage control signals and the instruction memory port. It computes jump and branch targets internally and keeps the fetch PC. It issues pipelined instruction-memory requests through a valid/ready handshake and buffers returned instructions in a FIFO toward decode. On redirect it flushes the FIFO and discards stale responses still in flight.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset; must be word-aligned.
- DEPTH, 4, FIFO entries and max requests in flight (outstanding + buffered); power of two, ≥2.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ct_jump  in  1  execute stage holds a J-type jump.
- ct_branch  in  1  execute stage holds a conditional branch.
- alu_zero  in  1  branch condition; taken when ct_branch && alu_zero.
- ex_pc  in  32  PC of the instruction in execute.
- ex_inst  in  32  instruction word in execute.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_resp_valid  in  1  in-order response; no backpressure.
- imem_resp_data  in  32  returned instruction.
- inst_valid  out  1  FIFO head valid toward decode.
- inst_ready  in  1  decode consumes head.
- inst_data  out  32  head instruction.
- inst_pc  out  32  PC of head instruction.

## Operation
- redirect = ct_jump || (ct_branch && alu_zero). ct_jump has priority.
- Jump target = {ex_pc_plus4[31:28], ex_inst[25:0], 2'b00}, where ex_pc_plus4 = ex_pc + 4.
- Branch target = ex_pc + 4 + (sign_ext(ex_inst[15:0]) << 2).
- All address arithmetic is mod 2^32.
- State:
  - fetch_pc: next address to request.
  - resp_pc: PC of the next kept response.
  - outstanding: 0..DEPTH.
  - drop_cnt: 0..DEPTH.
  - FIFO: DEPTH entries of {pc, inst}, with rd/wr pointers and count.
- Credit check: outstanding + fifo_count < DEPTH.
- imem_req_valid = credit && !redirect. Combinational; no other inputs.
- imem_req_addr = fetch_pc.
- Request accepted (valid && ready): fetch_pc += 4 and outstanding += 1.
- While a request is pending (valid && !ready), addr and valid stay stable. The only exceptions are redirect and reset.
- Response with drop_cnt > 0:
  - Discarded; drop_cnt -= 1 and outstanding -= 1.
- Response with drop_cnt == 0:
  - Pushed as {resp_pc, data}; resp_pc += 4 and outstanding -= 1.
  - Credit guarantees the FIFO is never full here.
- Response with outstanding == 0 is a protocol violation: ignored, no state change.
- Pop when inst_valid && inst_ready.
- inst_valid = fifo_count != 0; inst_data/inst_pc come from the head entry.
- Redirect cycle:
  - FIFO cleared; any pop and push that cycle are void.
  - fetch_pc and resp_pc are set to the target.
  - drop_cnt = outstanding − (1 if a response arrives this cycle and drop_cnt == 0, else 0) + drop-side adjustment. Net rule: every response whose request was accepted before the redirect is dropped.
  - No request is issued that cycle.
- Simultaneous accept, response and pop: all counters update consistently in the same edge.

## Timing
- Reset (async assert) values:
  - fetch_pc = resp_pc = RESET_PC.
  - outstanding = drop_cnt = fifo_count = 0.
  - inst_valid = 0.
  - imem_req_valid = 1 from the first cycle after rst_n deasserts.
- Response earliest one cycle after acceptance.
- Response at edge N makes inst_valid visible at cycle N+1. No bypass; minimum fetch-to-decode latency is 2 cycles.
- Redirect at cycle R: imem_req_valid = 0 in R; the target request is presented in R+1. inst_valid = 0 from R+1 until the first target response is pushed.
- Reset mid-operation clears all state. Responses to pre-reset requests are the memory's responsibility: it must be reset together with this block.
- Full throughput: one instruction per cycle when the memory returns 1-cycle responses and decode is always ready.

## Test plan
- Reset release, ready=1, 1-cycle memory returning addr as data, inst_ready=1:
  - Requests go to 0,4,8,…
  - inst_pc/inst_data = 0,4,8 on consecutive cycles from cycle 2.
- inst_ready=0 with DEPTH=4:
  - Exactly 4 requests issue, then imem_req_valid=0.
  - FIFO holds pcs 0..12.
  - Releasing inst_ready restarts requests at 16.
- imem_req_ready low for 3 cycles with valid high: imem_req_addr stays at 8 throughout.
- Jump with ex_pc=0x1000_0040, ex_inst[25:0]=0x0000100, 3-cycle memory latency, 2 requests outstanding:
  - Next request addr = 0x1000_0400.
  - Both stale responses are dropped.
  - First inst_pc = 0x1000_0400.
- Taken branch, ex_pc=0x100, imm16=0xFFFE: target 0xFC. With alu_zero=0, no redirect occurs and sequential fetch continues.
- rst_n asserted while 2 requests are outstanding and the FIFO is non-empty:
  - All outputs are at reset values immediately (async).
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit: PC/redirect logic, pipelined imem requests, response FIFO
// DEPTH must be a power of two >= 2; RESET_PC must be word-aligned.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ct_jump,
   input  logic        ct_branch,
   input  logic        alu_zero,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_inst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [AW-1:0] ONE_P   = AW'(1);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [CW-1:0] fifo_count_q, fifo_count_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   fifo_pc_q   [DEPTH];
   logic [31:0]   fifo_inst_q [DEPTH];

   logic [31:0] ex_pc_plus4, jump_target, branch_off, branch_target, target;
   logic [CW:0] in_use;
   logic        redirect, credit;
   logic        req_fire, resp_fire, resp_drop, resp_keep, pop, push;
   logic        unused_ex_bits;

   assign unused_ex_bits = ^ex_inst[31:26];

   assign ex_pc_plus4   = ex_pc + 32'd4;
   assign jump_target   = {ex_pc_plus4[31:28], ex_inst[25:0], 2'b00};
   assign branch_off    = {{14{ex_inst[15]}}, ex_inst[15:0], 2'b00};
   assign branch_target = ex_pc_plus4 + branch_off;
   assign redirect      = ct_jump || (ct_branch && alu_zero);
   assign target        = ct_jump ? jump_target : branch_target;

   // Requests in flight plus buffered entries never exceed the FIFO size.
   assign in_use = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
   assign credit = in_use < DEPTH_W;

   assign imem_req_valid = credit && !redirect;
   assign imem_req_addr  = fetch_pc_q;

   assign req_fire  = imem_req_valid && imem_req_ready;
   assign resp_fire = imem_resp_valid && (outstanding_q != '0);
   assign resp_drop = resp_fire && (drop_cnt_q != '0);
   assign resp_keep = resp_fire && (drop_cnt_q == '0);

   assign inst_valid = fifo_count_q != '0;
   assign inst_data  = fifo_inst_q[rd_ptr_q];
   assign inst_pc    = fifo_pc_q[rd_ptr_q];

   assign pop  = inst_valid && inst_ready && !redirect;
   assign push = resp_keep && !redirect;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      fifo_count_d  = fifo_count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;

      if (req_fire && !resp_fire) begin
         outstanding_d = outstanding_q + ONE_C;
      end else if (!req_fire && resp_fire) begin
         outstanding_d = outstanding_q - ONE_C;
      end

      if (redirect) begin
         // No request issues this cycle, so everything still in flight is stale.
         fetch_pc_d   = target;
         resp_pc_d    = target;
         drop_cnt_d   = outstanding_d;
         fifo_count_d = '0;
         rd_ptr_d     = '0;
         wr_ptr_d     = '0;
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (resp_drop) begin
            drop_cnt_d = drop_cnt_q - ONE_C;
         end
         if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + ONE_P;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE_P;
         end
         case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + ONE_C;
            2'b01:   fifo_count_d = fifo_count_q - ONE_C;
            default: fifo_count_d = fifo_count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         fifo_count_q  <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         fifo_count_q  <= fifo_count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
         fifo_inst_q[wr_ptr_q] <= imem_resp_data;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        ct_jump, ct_branch, alu_zero;
   logic [31:0] ex_pc, ex_inst;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid, inst_ready;
   logic [31:0] inst_data, inst_pc;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int mem_lat = 1;

   logic [31:0] pend_addr [$];
   int          pend_due  [$];
   logic [31:0] acc_q     [$];

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .ct_jump(ct_jump), .ct_branch(ct_branch), .alu_zero(alu_zero),
      .ex_pc(ex_pc), .ex_inst(ex_inst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_data(inst_data), .inst_pc(inst_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Memory returns the request address as data after mem_lat cycles, in order.
   task automatic tick();
      if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = pend_addr.pop_front();
         void'(pend_due.pop_front());
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'hDEAD_BEEF;
      end
      #1;
      if (imem_req_valid && imem_req_ready) begin
         pend_addr.push_back(imem_req_addr);
         pend_due.push_back(cyc + mem_lat);
         acc_q.push_back(imem_req_addr);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ct_jump = 1'b0; ct_branch = 1'b0; alu_zero = 1'b0;
      ex_pc = '0; ex_inst = '0;
      imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
      inst_ready = 1'b1;
      pend_addr.delete(); pend_due.delete(); acc_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_cmp++;
      if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_inst_valid got %0b want 0", inst_valid); end
      n_cmp++;
      if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got %08h want 00000000", imem_req_addr); end
      do_reset();
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL reset_first_req_valid got %0b want 1", imem_req_valid); end
   endtask

   task automatic test_sequential();
      do_reset();
      mem_lat = 1;
      for (int c = 0; c < 8; c++) begin
         #1;
         n_cmp++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4*c)) begin
            n_bad++; $display("FAIL seq_req c=%0d got v=%0b a=%08h want v=1 a=%08h", c, imem_req_valid, imem_req_addr, 4*c);
         end
         if (c >= 2) begin
            n_cmp++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'(4*(c-2)) || inst_data !== 32'(4*(c-2))) begin
               n_bad++; $display("FAIL seq_inst c=%0d got v=%0b pc=%08h d=%08h want pc=d=%08h", c, inst_valid, inst_pc, inst_data, 4*(c-2));
            end
         end else begin
            n_cmp++;
            if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL seq_early_valid c=%0d got %0b want 0", c, inst_valid); end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      mem_lat = 1;
      inst_ready = 1'b0;
      repeat (8) tick();
      n_cmp++;
      if (acc_q.size() != 4) begin n_bad++; $display("FAIL bp_req_count got %0d want 4", acc_q.size()); end
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_req_valid got %0b want 0", imem_req_valid); end
      inst_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (inst_valid !== 1'b1 || inst_pc !== 32'(4*k) || inst_data !== 32'(4*k)) begin
            n_bad++; $display("FAIL bp_drain k=%0d got v=%0b pc=%08h d=%08h want %08h", k, inst_valid, inst_pc, inst_data, 4*k);
         end
         tick();
      end
      n_cmp++;
      if (acc_q.size() < 5 || acc_q[4] !== 32'd16) begin
         n_bad++; $display("FAIL bp_restart_addr got n=%0d a=%08h want 00000010", acc_q.size(), (acc_q.size() >= 5) ? acc_q[4] : 32'hX);
      end
   endtask

   task automatic test_req_stall();
      do_reset();
      mem_lat = 1;
      tick(); tick();
      imem_req_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'd8) begin
            n_bad++; $display("FAIL stall_hold k=%0d got v=%0b a=%08h want v=1 a=00000008", k, imem_req_valid, imem_req_addr);
         end
         tick();
      end
      imem_req_ready = 1'b1;
      tick();
      n_cmp++;
      if (acc_q.size() != 3 || acc_q[2] !== 32'd8) begin
         n_bad++; $display("FAIL stall_accept got n=%0d want 3 with last 00000008", acc_q.size());
      end
      #1;
      n_cmp++;
      if (imem_req_addr !== 32'd12) begin n_bad++; $display("FAIL stall_next_addr got %08h want 0000000c", imem_req_addr); end
   endtask

   task automatic test_jump();
      do_reset();
      mem_lat = 3;
      tick(); tick();
      ex_pc = 32'h1000_0040; ex_inst = 32'h0800_0100; ct_jump = 1'b1;
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL jump_req_blocked got %0b want 0", imem_req_valid); end
      tick();
      ct_jump = 1'b0; ex_pc = '0; ex_inst = '0;
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1000_0400) begin
         n_bad++; $display("FAIL jump_target got v=%0b a=%08h want v=1 a=10000400", imem_req_valid, imem_req_addr);
      end
      n_cmp++;
      if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL jump_flush got %0b want 0", inst_valid); end
      for (int k = 0; k < 20 && !inst_valid; k++) tick();
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h1000_0400 || inst_data !== 32'h1000_0400) begin
         n_bad++; $display("FAIL jump_first_inst got v=%0b pc=%08h d=%08h want 10000400", inst_valid, inst_pc, inst_data);
      end
      tick();
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h1000_0404 || inst_data !== 32'h1000_0404) begin
         n_bad++; $display("FAIL jump_second_inst got v=%0b pc=%08h d=%08h want 10000404", inst_valid, inst_pc, inst_data);
      end
   endtask

   task automatic test_branch();
      do_reset();
      mem_lat = 1;
      tick(); tick();
      ex_pc = 32'h0000_0100; ex_inst = 32'h1000_FFFE; ct_branch = 1'b1; alu_zero = 1'b0;
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'd8) begin
         n_bad++; $display("FAIL br_not_taken got v=%0b a=%08h want v=1 a=00000008", imem_req_valid, imem_req_addr);
      end
      tick();
      n_cmp++;
      if (imem_req_addr !== 32'd12) begin n_bad++; $display("FAIL br_seq_next got %08h want 0000000c", imem_req_addr); end
      alu_zero = 1'b1;
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL br_req_blocked got %0b want 0", imem_req_valid); end
      tick();
      ct_branch = 1'b0; alu_zero = 1'b0;
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_00FC || inst_valid !== 1'b0) begin
         n_bad++; $display("FAIL br_target got v=%0b a=%08h iv=%0b want v=1 a=000000fc iv=0", imem_req_valid, imem_req_addr, inst_valid);
      end
      for (int k = 0; k < 20 && !inst_valid; k++) tick();
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_00FC || inst_data !== 32'h0000_00FC) begin
         n_bad++; $display("FAIL br_first_inst got v=%0b pc=%08h d=%08h want 000000fc", inst_valid, inst_pc, inst_data);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      mem_lat = 2;
      inst_ready = 1'b0;
      repeat (3) tick();
      #1;
      n_cmp++;
      if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_precond got %0b want 1", inst_valid); end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (inst_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
         n_bad++; $display("FAIL midrst_async got iv=%0b a=%08h want iv=0 a=00000000", inst_valid, imem_req_addr);
      end
      do_reset();
      mem_lat = 1;
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         n_bad++; $display("FAIL midrst_restart got v=%0b a=%08h want v=1 a=00000000", imem_req_valid, imem_req_addr);
      end
      for (int k = 0; k < 20 && !inst_valid; k++) tick();
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h0) begin
         n_bad++; $display("FAIL midrst_first_inst got v=%0b pc=%08h d=%08h want 00000000", inst_valid, inst_pc, inst_data);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      ct_jump = 1'b0; ct_branch = 1'b0; alu_zero = 1'b0;
      ex_pc = '0; ex_inst = '0;
      imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
      inst_ready = 1'b1;
      test_reset();
      test_sequential();
      test_backpressure();
      test_req_stall();
      test_jump();
      test_branch();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
